fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding/hazard unit for the RISC-V core pipeline; successor to the fixed two-stage X/WB forwarding logic.
- Tracks in-flight register writes in a DEPTH-entry shift scoreboard, each entry with a result-ready countdown.
- Per source operand in ID, produces a forward-select index (0 = register file, k = stage k). Raises stall when the youngest matching producer's result is not yet ready, e.g. load-use or multi-cycle ops.

Parameters:
- REG_AW, 5, register index width.
- DEPTH, 3, tracked stages after ID; entry 0 = X, entry DEPTH-1 = last stage with a forward path.
- NSRC, 2, source operands checked per instruction.
- LAT_W, 2, width of issue latency/countdown field.
- SELW, $clog2(DEPTH+1), derived; width of one forward select.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- issue_valid  input  1  instruction in ID moves into X this cycle (ignored when stall or flush)
- issue_wen  input  1  issued instruction writes rd
- issue_rd  input  REG_AW  destination register of issued instruction
- issue_lat  input  LAT_W  cycles after entering X until result is forwardable; 0 = ALU, 1 = load; must be < DEPTH
- flush  input  1  ID instruction is killed (branch/jump resolved)
- rs_id  input  NSRC*REG_AW  source register indices in ID, operand j at bits [j*REG_AW +: REG_AW]
- rs_used  input  NSRC  operand j actually read by the ID instruction
- fwd_sel  output  NSRC*SELW  per-operand select: 0 = RF, k = value from entry k-1
- stall  output  1  hold PC/IF/ID, inject bubble into X

Behaviour:
- Entry fields: valid, wen, rd, cnt[LAT_W-1:0]. Reset clears all valid bits asynchronously. Outputs are then fwd_sel = 0 and stall = 0.
- Every clock: entry[i] <= entry[i-1] for i ≥ 1. Entry[DEPTH-1] is discarded; it is committed to the RF, which is write-first.
- Entry[0] load rule: gets {1, issue_wen, issue_rd, issue_lat} when issue_valid & !stall & !flush. Otherwise it becomes a bubble (valid = 0).
- Each shifted entry's cnt decrements, saturating at 0. Shifting continues during stall; only ID/IF are held.
- Match for operand j: rs_used[j], rs_id[j] != 0, entry valid & wen & rd == rs_id[j].
- Priority: the lowest index (youngest) match wins. Older matches are ignored.
- If the winning entry's cnt == 0: fwd_sel[j] = index+1.
- If the winning entry's cnt != 0: operand-j hazard. fwd_sel[j] = 0 (don't-care).
- If no match: fwd_sel[j] = 0.
- stall = OR of operand hazards, forced 0 when flush. A killed instruction never stalls.
- x0 never forwards and never stalls.
- fwd_sel and stall are combinational from scoreboard state and ID inputs. There is no added latency.
- Simultaneous issue and retire of the same rd: the younger entry wins by priority.
- Reset mid-operation: all entries clear immediately. No stale forward after rst deasserts.
- issue_lat ≥ DEPTH is illegal. A simulation assertion fires if an entry leaves entry[DEPTH-1] with cnt != 0.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- Defined: adds output ports stall_cycles[31:0] and fwd_events[31:0], both cleared by rst.
  - stall_cycles increments each cycle stall = 1.
  - fwd_events increments by the number of operands with nonzero fwd_sel in a non-stalled cycle.
  - Both wrap at 2^32.
- Undefined: ports and counters absent. Core behaviour is identical.

Test Plan:
- Back-to-back ALU: issue rd=5 lat=0, next ID has rs1=5 used → stall=0, fwd_sel[0]=1. One cycle later, rs1=5 → fwd_sel[0]=2.
- Load-use: issue rd=7 lat=1, ID rs2=7 → stall=1 for exactly 1 cycle, then fwd_sel[1]=2, stall=0.
- Priority: rd=3 issued twice consecutively, ID rs1=3 → fwd_sel[0]=1 (youngest), not 2.
- x0 and unused operands: issue rd=0 wen=1, ID rs1=0 → fwd_sel=0, stall=0. Issue rd=4, ID rs2=4 with rs_used[1]=0 → fwd_sel=0, stall=0.
- Flush: issue rd=7 lat=1, ID rs1=7 with flush=1 → stall=0, entry[0] bubble next cycle. Retire past DEPTH → fwd_sel=0 (RF).
- Async reset: mid-sequence with valid entries, assert rst between clock edges → fwd_sel=0, stall=0 immediately, and they stay 0 after release until a new issue.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and hazard detection for the core pipeline.
// A DEPTH-entry shift scoreboard follows in-flight register writes from X onward.
// Each entry has a countdown to the cycle its result can be forwarded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/wen/rd/lat   instruction leaving ID into X (rd write, latency)
//   flush                    ID instruction killed this cycle
//   rs_id, rs_used           ID source operands (packed, REG_AW bits each) and use mask
//   fwd_sel                  per-operand select: 0 = RF, k = entry k-1 (combinational)
//   stall                    hold IF/ID, bubble into X (combinational)
//   stall_cycles, fwd_events statistics counters, present only with FWD_SCOREBOARD_STATS_EN
//
// Optional feature macro: FWD_SCOREBOARD_STATS_EN
module fwd_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned LAT_W  = 2,
  parameter int unsigned SELW   = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic                     flush,
  input  logic [NSRC*REG_AW-1:0]   rs_id,
  input  logic [NSRC-1:0]          rs_used,
  output logic [NSRC*SELW-1:0]     fwd_sel,
`ifdef FWD_SCOREBOARD_STATS_EN
  output logic [31:0]              stall_cycles,
  output logic [31:0]              fwd_events,
`endif
  output logic                     stall
);

  // Scoreboard state; index 0 is the X stage (youngest).
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wen_q, wen_d;
  logic [REG_AW-1:0] rd_q  [DEPTH];
  logic [REG_AW-1:0] rd_d  [DEPTH];
  logic [LAT_W-1:0]  cnt_q [DEPTH];
  logic [LAT_W-1:0]  cnt_d [DEPTH];

  logic [NSRC*SELW-1:0] fwd_sel_c;
  logic [NSRC-1:0]      hazard_c;
  logic                 stall_c;
  logic                 load_c;

  // Operand match: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_sel_c = '0;
    hazard_c  = '0;
    for (int j = 0; j < int'(NSRC); j++) begin
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (rs_used[j] && (rs_id[j*REG_AW +: REG_AW] != '0) && valid_q[i] && wen_q[i] &&
            (rd_q[i] == rs_id[j*REG_AW +: REG_AW])) begin
          if (cnt_q[i] == '0) begin
            fwd_sel_c[j*SELW +: SELW] = SELW'(i + 1);
            hazard_c[j]               = 1'b0;
          end else begin
            fwd_sel_c[j*SELW +: SELW] = '0;
            hazard_c[j]               = 1'b1;
          end
        end
      end
    end
    // A killed ID instruction never waits on a producer.
    stall_c = (|hazard_c) & ~flush;
  end

  assign fwd_sel = fwd_sel_c;
  assign stall   = stall_c;

  // Next scoreboard state: shift every cycle, load X only on a real issue.
  always_comb begin
    load_c     = issue_valid & ~stall_c & ~flush;
    valid_d    = '0;
    wen_d      = '0;
    valid_d[0] = load_c;
    wen_d[0]   = load_c & issue_wen;
    rd_d[0]    = load_c ? issue_rd : '0;
    cnt_d[0]   = load_c ? issue_lat : '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      wen_d[i]   = wen_q[i-1];
      rd_d[i]    = rd_q[i-1];
      cnt_d[i]   = (cnt_q[i-1] == '0) ? '0 : cnt_q[i-1] - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wen_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_events_q, fwd_events_d;
  logic [31:0] nz_c;

  // Statistics: stall cycles and forwarded operands in non-stalled cycles.
  always_comb begin
    nz_c = '0;
    for (int j = 0; j < int'(NSRC); j++) begin
      if (fwd_sel_c[j*SELW +: SELW] != '0) nz_c = nz_c + 32'd1;
    end
    stall_cycles_d = stall_cycles_q + (stall_c ? 32'd1 : 32'd0);
    fwd_events_d   = fwd_events_q + (stall_c ? 32'd0 : nz_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

  // An entry retiring with a nonzero countdown means an illegal issue latency.
  a_retire_ready: assert property (@(posedge clk) disable iff (rst)
    !(valid_q[DEPTH-1] && (cnt_q[DEPTH-1] != '0)));

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Randomized and directed bench for fwd_scoreboard against an age-based issue-log model.
module tb_fwd_scoreboard;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned LAT_W  = 2;
  localparam int unsigned SELW   = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid, issue_wen, flush;
  logic [REG_AW-1:0]      issue_rd;
  logic [LAT_W-1:0]       issue_lat;
  logic [NSRC*REG_AW-1:0] rs_id;
  logic [NSRC-1:0]        rs_used;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]            stall_cycles, fwd_events;
`endif

  fwd_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NSRC(NSRC), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush), .rs_id(rs_id),
    .rs_used(rs_used), .fwd_sel(fwd_sel),
`ifdef FWD_SCOREBOARD_STATS_EN
    .stall_cycles(stall_cycles), .fwd_events(fwd_events),
`endif
    .stall(stall)
  );

  always #5 clk = ~clk;

  // Model: log of issued writes with the cycle they entered X; age = now - t.
  typedef struct {
    int rd;
    bit wen;
    int lat;
    int t;
  } ent_t;
  ent_t q[$];
  int   cyc;
  int   exp_sel[NSRC];
  bit   exp_stall;
  int unsigned m_stall_cycles, m_fwd_events;
  int   passed, total;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int dut_sel(input int j);
    return int'(fwd_sel[j*SELW +: SELW]);
  endfunction

  // Youngest in-flight writer of a register decides: forward at age+1 once age >= latency.
  function automatic void model_eval();
    exp_stall = 1'b0;
    for (int j = 0; j < int'(NSRC); j++) begin
      int rs;
      rs = int'(rs_id[j*REG_AW +: REG_AW]);
      exp_sel[j] = 0;
      if (rs_used[j] && rs != 0) begin
        for (int k = 0; k < q.size(); k++) begin
          int age;
          age = cyc - q[k].t;
          if (age < int'(DEPTH) && q[k].wen && q[k].rd == rs) begin
            if (age >= q[k].lat) exp_sel[j] = age + 1;
            else if (!flush) exp_stall = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  task automatic check_outputs();
    #1;
    model_eval();
    for (int j = 0; j < int'(NSRC); j++) chk($sformatf("fwd_sel[%0d]", j), dut_sel(j), exp_sel[j]);
    chk("stall", int'(stall), int'(exp_stall));
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_stall) m_stall_cycles++;
    else for (int j = 0; j < int'(NSRC); j++) if (exp_sel[j] != 0) m_fwd_events++;
    cyc++;
    if (issue_valid && !exp_stall && !flush)
      q.push_front('{rd: int'(issue_rd), wen: issue_wen, lat: int'(issue_lat), t: cyc});
    while (q.size() > 0 && (cyc - q[$].t) >= int'(DEPTH)) void'(q.pop_back());
    @(negedge clk);
  endtask

  task automatic set_issue(input bit v, input bit w, input int rd, input int lat);
    issue_valid = v;
    issue_wen   = w;
    issue_rd    = REG_AW'(rd);
    issue_lat   = LAT_W'(lat);
  endtask

  task automatic set_id(input int rs0, input int rs1, input int used, input bit fl);
    rs_id   = {REG_AW'(rs1), REG_AW'(rs0)};
    rs_used = NSRC'(used);
    flush   = fl;
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0;
    m_stall_cycles = 0; m_fwd_events = 0;
    rst = 1'b1;
    set_issue(0, 0, 0, 0);
    set_id(5, 7, 3, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset fwd_sel[0]", dut_sel(0), 0);
    chk("reset fwd_sel[1]", dut_sel(1), 0);
    chk("reset stall", int'(stall), 0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back ALU
    set_issue(1, 1, 5, 0); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    set_issue(0, 0, 0, 0); set_id(5, 0, 1, 0);
    check_outputs();
    chk("alu sel age0", dut_sel(0), 1); chk("alu stall", int'(stall), 0);
    advance();
    check_outputs();
    chk("alu sel age1", dut_sel(0), 2);
    advance();

    // Load-use: one stall cycle, then forward from entry 1
    set_issue(1, 1, 7, 1); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    set_issue(0, 0, 0, 0); set_id(0, 7, 2, 0);
    check_outputs();
    chk("load-use stall", int'(stall), 1);
    advance();
    check_outputs();
    chk("load-use stall released", int'(stall), 0);
    chk("load-use sel", dut_sel(1), 2);
    advance();

    // Priority: youngest of two writers
    set_issue(1, 1, 3, 0); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    check_outputs(); advance();
    set_issue(0, 0, 0, 0); set_id(3, 0, 1, 0);
    check_outputs();
    chk("priority youngest", dut_sel(0), 1);
    advance();

    // x0 and unused operand
    set_issue(1, 1, 0, 0); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    set_issue(1, 1, 4, 0); set_id(0, 0, 1, 0);
    check_outputs();
    chk("x0 sel", dut_sel(0), 0); chk("x0 stall", int'(stall), 0);
    advance();
    set_issue(0, 0, 0, 0); set_id(0, 4, 1, 0);
    check_outputs();
    chk("unused sel", dut_sel(1), 0); chk("unused stall", int'(stall), 0);
    advance();

    // Flush: hazard suppressed, killed instruction becomes a bubble
    set_issue(1, 1, 7, 1); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    set_issue(1, 1, 8, 0); set_id(7, 0, 1, 1);
    check_outputs();
    chk("flush stall", int'(stall), 0);
    advance();
    set_issue(0, 0, 0, 0); set_id(8, 0, 1, 0);
    check_outputs();
    chk("flush bubble", dut_sel(0), 0);
    advance();
    repeat (DEPTH) begin check_outputs(); advance(); end
    set_id(7, 0, 1, 0);
    check_outputs();
    chk("retired to RF", dut_sel(0), 0);
    advance();

    // Asynchronous reset between edges
    set_issue(1, 1, 9, 0); set_id(0, 0, 0, 0);
    check_outputs(); advance();
    set_issue(0, 0, 0, 0); set_id(9, 0, 1, 0);
    check_outputs();
    chk("pre-reset sel", dut_sel(0), 1);
    #1 rst = 1'b1;
    #1;
    chk("async reset sel", dut_sel(0), 0);
    chk("async reset stall", int'(stall), 0);
    q.delete(); m_stall_cycles = 0; m_fwd_events = 0;
    #1 rst = 1'b0;
    model_eval();
    advance();
    check_outputs();
    chk("post-reset sel", dut_sel(0), 0);
    advance();

    // Randomized traffic over a small register set to provoke hits
    for (int n = 0; n < 600; n++) begin
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, DEPTH - 1)));
      set_id(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
      check_outputs();
      advance();
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    #1;
    chk("stall_cycles", int'(stall_cycles), int'(m_stall_cycles));
    chk("fwd_events", int'(fwd_events), int'(m_fwd_events));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
